// File: rtl/lv1_lv2_bus_arbiter.sv
// Round-robin arbiter for the shared lv1<->lv2 bus: one processor-side owner
// at a time, plus one snoop-side responder while the owner's transaction is open.
module lv1_lv2_bus_arbiter #(
  parameter int unsigned NUM_CORE    = 4,
  parameter int unsigned CORE_ID_WID = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_CORE-1:0]    bus_lv1_lv2_req_proc,
  input  logic [NUM_CORE-1:0]    bus_lv1_lv2_req_snoop,
  output logic [NUM_CORE-1:0]    bus_lv1_lv2_gnt_proc,
  output logic [NUM_CORE-1:0]    bus_lv1_lv2_gnt_snoop,
  output logic [CORE_ID_WID-1:0] proc_owner,
  output logic                   bus_busy
);

  typedef enum logic [1:0] {IDLE, PROC, SNOOP} state_t;

  state_t                 state;
  logic [CORE_ID_WID-1:0] last_proc;
  logic [CORE_ID_WID-1:0] last_snoop;
  logic [CORE_ID_WID-1:0] snoop_owner;
  logic [CORE_ID_WID-1:0] proc_win;
  logic [CORE_ID_WID-1:0] snoop_win;
  logic                   proc_hit;
  logic                   snoop_hit;

  // Winner search from pointer+1, wrapping; the current owner never competes for snoop
  always_comb begin : search
    logic [CORE_ID_WID-1:0] idx;
    idx       = '0;
    proc_hit  = 1'b0;
    proc_win  = '0;
    snoop_hit = 1'b0;
    snoop_win = '0;
    for (int unsigned i = 1; i <= NUM_CORE; i++) begin
      idx = CORE_ID_WID'((32'(last_proc) + i) % NUM_CORE);
      if (!proc_hit && bus_lv1_lv2_req_proc[idx]) begin
        proc_hit = 1'b1;
        proc_win = idx;
      end
    end
    for (int unsigned i = 1; i <= NUM_CORE; i++) begin
      idx = CORE_ID_WID'((32'(last_snoop) + i) % NUM_CORE);
      if (!snoop_hit && bus_lv1_lv2_req_snoop[idx] && (idx != proc_owner)) begin
        snoop_hit = 1'b1;
        snoop_win = idx;
      end
    end
  end

  // Arbitration FSM with registered grants, owner and busy flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state                 <= IDLE;
      bus_lv1_lv2_gnt_proc  <= '0;
      bus_lv1_lv2_gnt_snoop <= '0;
      proc_owner            <= '0;
      bus_busy              <= 1'b0;
      snoop_owner           <= '0;
      last_proc             <= CORE_ID_WID'(NUM_CORE - 1);
      last_snoop            <= CORE_ID_WID'(NUM_CORE - 1);
    end else begin
      unique case (state)
        IDLE: begin
          if (proc_hit) begin
            state                <= PROC;
            bus_lv1_lv2_gnt_proc <= NUM_CORE'(1) << proc_win;
            proc_owner           <= proc_win;
            last_proc            <= proc_win;
            bus_busy             <= 1'b1;
          end
        end
        PROC: begin
          if (!bus_lv1_lv2_req_proc[proc_owner]) begin
            state                <= IDLE;
            bus_lv1_lv2_gnt_proc <= '0;
            bus_busy             <= 1'b0;
          end else if (snoop_hit) begin
            state                 <= SNOOP;
            bus_lv1_lv2_gnt_snoop <= NUM_CORE'(1) << snoop_win;
            snoop_owner           <= snoop_win;
            last_snoop            <= snoop_win;
          end
        end
        SNOOP: begin
          // Processor grant is held until the snoop responder lets go
          if (!bus_lv1_lv2_req_snoop[snoop_owner]) begin
            bus_lv1_lv2_gnt_snoop <= '0;
            if (bus_lv1_lv2_req_proc[proc_owner]) begin
              state <= PROC;
            end else begin
              state                <= IDLE;
              bus_lv1_lv2_gnt_proc <= '0;
              bus_busy             <= 1'b0;
            end
          end
        end
        default: begin
          state                 <= IDLE;
          bus_lv1_lv2_gnt_proc  <= '0;
          bus_lv1_lv2_gnt_snoop <= '0;
          bus_busy              <= 1'b0;
        end
      endcase
    end
  end

endmodule
